// File: rtl/vu_pkg.sv
// vu_pkg: shared types and elaboration-time helpers for the VU peak meter.
//   vu_state_e   - peak tracker state (IDLE / HOLD / DECAY)
//   calc_maxmag  - largest representable magnitude of a w-bit two's-complement sample
//   calc_th      - bar-graph threshold for LED segment i of n
package vu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } vu_state_e;

  function automatic int calc_maxmag(int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Truncating division keeps the top segment exactly at full scale.
  function automatic int calc_th(int i, int n, int w);
    return ((i + 1) * calc_maxmag(w)) / n;
  endfunction

endpackage

// File: rtl/vu_thermo_encoder.sv
// vu_thermo_encoder: registered thermometer bar from a peak magnitude.
//   clk     - system clock
//   rst_n   - asynchronous active-low reset (clears the bar)
//   pk      - peak magnitude, W_SAMPLE-1 bits unsigned
//   leds    - N_LED-bit bar, bit 0 = lowest segment, one cycle after pk
module vu_thermo_encoder
  import vu_pkg::*;
#(
  parameter int W_SAMPLE = 12,
  parameter int N_LED    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W_SAMPLE-2:0]   pk,
  output logic [N_LED-1:0]      leds
);

  localparam int MW = W_SAMPLE - 1;

  logic [N_LED-1:0] leds_d, leds_q;

  // Thresholds rise with i, so the per-segment compares are monotone by construction.
  function automatic logic [MW-1:0] th_of(int i);
    int t;
    t = calc_th(i, N_LED, W_SAMPLE);
    return t[MW-1:0];
  endfunction

  always_comb begin
    leds_d = '0;
    for (int i = 0; i < N_LED; i++) begin
      leds_d[i] = (pk >= th_of(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) leds_q <= '0;
    else        leds_q <= leds_d;
  end

  assign leds = leds_q;

endmodule

// File: rtl/vu_peak_meter.sv
// vu_peak_meter: peak-hold / linear-decay level meter with sticky clip.
//   clk_in        - system clock (same clock as the tick generator)
//   rst           - asynchronous active-low reset
//   tick_in       - display tick level, edge-detected here (not a clock)
//   sample_valid  - qualifies sample
//   sample        - signed audio sample
//   clip_clr      - clears the clip flag (a simultaneous full-scale sample wins)
//   level         - current peak magnitude
//   leds          - thermometer bar, one cycle behind level
//   clip          - sticky full-scale indicator
//   hold_active   - high while the peak is being held
module vu_peak_meter
  import vu_pkg::*;
#(
  parameter int W_SAMPLE   = 12,
  parameter int N_LED      = 8,
  parameter int HOLD_TICKS = 4,
  parameter int DECAY_STEP = 64
) (
  input  logic                       clk_in,
  input  logic                       rst,
  input  logic                       tick_in,
  input  logic                       sample_valid,
  input  logic signed [W_SAMPLE-1:0] sample,
  input  logic                       clip_clr,
  output logic [W_SAMPLE-2:0]        level,
  output logic [N_LED-1:0]           leds,
  output logic                       clip,
  output logic                       hold_active
);

  localparam int MW        = W_SAMPLE - 1;
  localparam int HC_W      = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam int MAXMAG_I  = calc_maxmag(W_SAMPLE);
  localparam logic [MW-1:0]   MAXMAG = MAXMAG_I[MW-1:0];
  localparam logic [MW-1:0]   STEP   = DECAY_STEP[MW-1:0];
  localparam logic [HC_W-1:0] HOLD_N = HOLD_TICKS[HC_W-1:0];

  vu_state_e        state_d, state_q;
  logic [MW-1:0]    pk_d, pk_q;
  logic [HC_W-1:0]  hold_cnt_d, hold_cnt_q;
  logic             tick_d, tick_q;
  logic             clip_d, clip_q;

  logic signed [W_SAMPLE-1:0] mag_full;
  logic [MW-1:0]              mag;
  logic                       tick_rise;
  logic                       capture;

  // Negating the most-negative code yields itself; its set top bit marks the
  // one case that must saturate.
  always_comb begin
    mag_full = sample[W_SAMPLE-1] ? -sample : sample;
    mag      = mag_full[W_SAMPLE-1] ? MAXMAG : mag_full[MW-1:0];
  end

  assign tick_d    = tick_in;
  assign tick_rise = tick_in & ~tick_q;
  assign capture   = sample_valid && (mag > pk_q);

  // Next-state: capture overrides any tick arriving in the same cycle.
  always_comb begin
    state_d    = state_q;
    pk_d       = pk_q;
    hold_cnt_d = hold_cnt_q;
    if (capture) begin
      pk_d       = mag;
      hold_cnt_d = HOLD_N;
      state_d    = (HOLD_TICKS == 0) ? DECAY : HOLD;
    end else if (tick_rise) begin
      case (state_q)
        HOLD: begin
          if (hold_cnt_q <= HC_W'(1)) state_d = DECAY;
          else                        hold_cnt_d = hold_cnt_q - HC_W'(1);
        end
        DECAY: begin
          if (pk_q > STEP) begin
            pk_d = pk_q - STEP;
          end else begin
            pk_d    = '0;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    clip_d = clip_q;
    if (sample_valid && (mag == MAXMAG)) clip_d = 1'b1;
    else if (clip_clr)                   clip_d = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pk_q       <= '0;
      hold_cnt_q <= '0;
      tick_q     <= 1'b0;
      clip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pk_q       <= pk_d;
      hold_cnt_q <= hold_cnt_d;
      tick_q     <= tick_d;
      clip_q     <= clip_d;
    end
  end

  vu_thermo_encoder #(
    .W_SAMPLE (W_SAMPLE),
    .N_LED    (N_LED)
  ) u_thermo (
    .clk   (clk_in),
    .rst_n (rst),
    .pk    (pk_q),
    .leds  (leds)
  );

  assign level       = pk_q;
  assign clip        = clip_q;
  assign hold_active = (state_q == HOLD);

endmodule

// File: tb/tb_vu_peak_meter.sv
module tb_vu_peak_meter;

  logic               clk_in = 1'b0;
  logic               rst = 1'b0;
  logic               tick_in = 1'b0;
  logic               sample_valid = 1'b0;
  logic signed [11:0] sample = '0;
  logic               clip_clr = 1'b0;
  logic [10:0]        level;
  logic [7:0]         leds;
  logic               clip;
  logic               hold_active;

  int checks = 0;
  int failures = 0;

  vu_peak_meter #(
    .W_SAMPLE   (12),
    .N_LED      (8),
    .HOLD_TICKS (4),
    .DECAY_STEP (64)
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .tick_in      (tick_in),
    .sample_valid (sample_valid),
    .sample       (sample),
    .clip_clr     (clip_clr),
    .level        (level),
    .leds         (leds),
    .clip         (clip),
    .hold_active  (hold_active)
  );

  always #5 clk_in = ~clk_in;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // One tick period: rising edge seen on the first clock, then low.
  task automatic tick();
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    step();
  endtask

  task automatic apply_sample(input int s);
    sample       = 12'(s);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic chk_level(input string nm, input int exp_v);
    checks++;
    if (level !== 11'(exp_v)) begin
      failures++;
      $display("FAIL %s: level=%0d expected=%0d", nm, level, exp_v);
    end
  endtask

  task automatic chk_hold(input string nm, input logic exp_v);
    checks++;
    if (hold_active !== exp_v) begin
      failures++;
      $display("FAIL %s: hold_active=%b expected=%b", nm, hold_active, exp_v);
    end
  endtask

  task automatic chk_leds(input string nm, input logic [7:0] exp_v);
    checks++;
    if (leds !== exp_v) begin
      failures++;
      $display("FAIL %s: leds=%b expected=%b", nm, leds, exp_v);
    end
  endtask

  task automatic chk_clip(input string nm, input logic exp_v);
    checks++;
    if (clip !== exp_v) begin
      failures++;
      $display("FAIL %s: clip=%b expected=%b", nm, clip, exp_v);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    chk_level("reset_level", 0);
    chk_leds("reset_leds", 8'h00);
    chk_clip("reset_clip", 1'b0);
    chk_hold("reset_hold", 1'b0);
    step(); step();
    rst = 1'b1;
    step();
    chk_level("after_release_level", 0);
  endtask

  task automatic test_capture();
    apply_sample(800);
    chk_level("capture_level", 800);
    chk_hold("capture_hold", 1'b1);
    chk_leds("capture_leds_not_yet", 8'h00);
    step();
    chk_leds("capture_leds", 8'b0000_0111);
  endtask

  task automatic test_hold_decay();
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk_level($sformatf("hold_t%0d_level", t), 800);
      chk_hold($sformatf("hold_t%0d_active", t), 1'b1);
    end
    tick();
    chk_level("hold_t4_level", 800);
    chk_hold("hold_t4_active", 1'b0);
    for (int d = 1; d <= 12; d++) begin
      tick();
      chk_level($sformatf("decay_%0d", d), 800 - 64 * d);
    end
    tick();
    chk_level("decay_13_zero", 0);
    chk_leds("decay_13_leds", 8'h00);
    tick();
    chk_level("idle_ignores_tick", 0);
  endtask

  task automatic test_collision();
    apply_sample(500);
    for (int t = 0; t < 4; t++) tick();
    chk_hold("coll_in_decay", 1'b0);
    chk_level("coll_pre_level", 500);
    sample       = -12'sd600;
    sample_valid = 1'b1;
    tick_in      = 1'b1;
    step();
    sample_valid = 1'b0;
    tick_in      = 1'b0;
    chk_level("coll_capture_wins", 600);
    chk_hold("coll_hold_rearmed", 1'b1);
    step();
    for (int t = 1; t <= 3; t++) tick();
    chk_hold("coll_still_holding", 1'b1);
    tick();
    chk_hold("coll_hold_expired", 1'b0);
    chk_level("coll_level_held", 600);
    tick();
    chk_level("coll_first_decay", 536);
  endtask

  task automatic test_reset_mid_decay();
    apply_sample(1500);
    for (int t = 0; t < 4; t++) tick();
    tick();
    tick();
    chk_level("rmd_pre_level", 1372);
    #2 rst = 1'b0;
    #1;
    chk_level("rmd_async_level", 0);
    chk_leds("rmd_async_leds", 8'h00);
    chk_hold("rmd_async_hold", 1'b0);
    chk_clip("rmd_async_clip", 1'b0);
    step(); step(); step();
    rst = 1'b1;
    step();
    tick();
    tick();
    chk_level("rmd_no_decay_after", 0);
    chk_hold("rmd_idle", 1'b0);
  endtask

  task automatic test_clip();
    apply_sample(-2048);
    chk_level("sat_level", 2047);
    chk_clip("sat_clip", 1'b1);
    step();
    chk_leds("sat_leds", 8'hFF);
    sample       = -12'sd2048;
    sample_valid = 1'b1;
    clip_clr     = 1'b1;
    step();
    sample_valid = 1'b0;
    chk_clip("clip_set_wins", 1'b1);
    step();
    clip_clr = 1'b0;
    chk_clip("clip_cleared", 1'b0);
    step();
    chk_clip("clip_stays_clear", 1'b0);
  endtask

  task automatic test_equal_smaller();
    do_reset();
    apply_sample(1000);
    tick();
    tick();
    apply_sample(1000);
    chk_level("eq_level", 1000);
    chk_hold("eq_hold", 1'b1);
    apply_sample(300);
    chk_level("small_level", 1000);
    chk_hold("small_hold", 1'b1);
    tick();
    chk_hold("eq_cnt_1", 1'b1);
    tick();
    chk_hold("eq_not_rearmed", 1'b0);
    chk_level("eq_level_before_decay", 1000);
    tick();
    chk_level("eq_first_decay", 936);
  endtask

  initial begin
    test_reset();
    test_capture();
    test_hold_decay();
    test_collision();
    test_reset_mid_decay();
    test_clip();
    test_equal_smaller();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
